sdram_readback_checker: RTL and testbench



---
 rtl/sdram_test_pkg.sv | 30 +++
 rtl/sdram_addr_fifo.sv | 77 +++++++
 rtl/sdram_readback_checker.sv | 193 +++++++++++++++++++
 tb/tb_sdram_readback_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM pattern-fill writer and read-back checker.
// Both sides derive the expected word from expected_data so they always agree.
package sdram_test_pkg;

    localparam int ADDR_WIDTH = 25;
    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    // sel=0: fixed pattern; sel=1: the word holds the low 16 bits of its own address
    function automatic logic [DATA_WIDTH-1:0] expected_data(
        input logic [15:0]           addr_lo,
        input logic                  sel,
        input logic [DATA_WIDTH-1:0] pattern
    );
        logic [DATA_WIDTH-1:0] word;
        if (sel) begin
            word = addr_lo;
        end else begin
            word = pattern;
        end
        return word;
    endfunction

endpackage

// File: rtl/sdram_addr_fifo.sv
// Pending-read address FIFO: holds the address of every read issued but not yet returned.
// Depth must be a power of two so the pointers wrap naturally.
module sdram_addr_fifo
    import sdram_test_pkg::*;
#(
    parameter int Depth = 4,
    parameter int Width = ADDR_WIDTH,
    localparam int PtrW = $clog2(Depth),
    localparam int CntW = PtrW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CntW-1:0]  count
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push_s, do_pop_s;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == CntW'(0));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        do_push_s = push && (!full || pop);
        do_pop_s  = pop && !empty;
        if (clr) begin
            wr_ptr_d = PtrW'(0);
            rd_ptr_d = PtrW'(0);
            count_d  = CntW'(0);
        end else begin
            if (do_push_s) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CntW'(do_push_s) - CntW'(do_pop_s);
        end
    end

    // Storage carries no reset; only pointers and occupancy define validity
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q <= PtrW'(0);
            rd_ptr_q <= PtrW'(0);
            count_q  <= CntW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sdram_readback_checker.sv
// Issues reads over [StartAddr, EndAddr] and compares each returned word with the expected
// pattern, reporting pass/fail, a saturating mismatch count and the first failing word.
module sdram_readback_checker
    import sdram_test_pkg::*;
#(
    parameter int                   AddrWidth      = ADDR_WIDTH,
    parameter int                   DataWidth      = DATA_WIDTH,
    parameter logic [AddrWidth-1:0] StartAddr      = 25'h0000000,
    parameter logic [AddrWidth-1:0] EndAddr        = 25'h1FFFFFF,
    parameter logic [DataWidth-1:0] PatternConst   = 16'hCAFE,
    parameter int                   MaxOutstanding = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 patternSel,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [15:0]          errCount,
    output logic [AddrWidth-1:0] firstErrAddr,
    output logic [DataWidth-1:0] firstErrData,
    output logic                 protoErr,
    input  logic                 cmdReady,
    output logic                 cmdTrigger,
    output logic [AddrWidth-1:0] cmdAddr,
    output logic                 cmdWrite,
    input  logic [DataWidth-1:0] cmdReadData,
    input  logic                 cmdReadDataValid
);

    localparam int CntW = $clog2(MaxOutstanding) + 1;

    chk_state_e           state_q, state_d;
    logic                 cmd_trigger_q, cmd_trigger_d;
    logic [AddrWidth-1:0] cmd_addr_q, cmd_addr_d;
    logic                 pattern_sel_q, pattern_sel_d;
    logic [15:0]          err_count_q, err_count_d;
    logic [AddrWidth-1:0] first_err_addr_q, first_err_addr_d;
    logic [DataWidth-1:0] first_err_data_q, first_err_data_d;
    logic                 proto_err_q, proto_err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    logic                 accept_s, start_ok_s, run_active_s, rd_valid_s;
    logic                 push_s, pop_s, proto_hit_s, mismatch_s;
    logic [DataWidth-1:0] exp_data_s;
    logic [AddrWidth-1:0] fifo_head_s;
    logic                 fifo_full_s, fifo_empty_s;
    logic [CntW-1:0]      fifo_count_s, count_next_s;

    assign accept_s     = cmd_trigger_q && cmdReady;
    assign run_active_s = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign start_ok_s   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign rd_valid_s   = cmdReadDataValid && run_active_s;
    assign push_s       = accept_s && (!fifo_full_s || pop_s);
    assign pop_s        = rd_valid_s && !fifo_empty_s;
    assign proto_hit_s  = rd_valid_s && fifo_empty_s;
    assign exp_data_s   = expected_data(fifo_head_s[15:0], pattern_sel_q, PatternConst);
    assign mismatch_s   = pop_s && (cmdReadData != exp_data_s);

    sdram_addr_fifo #(
        .Depth (MaxOutstanding),
        .Width (AddrWidth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_ok_s),
        .push      (push_s),
        .push_data (cmd_addr_q),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Occupancy the FIFO will have next cycle, used to throttle the next request
    always_comb begin
        if (start_ok_s) begin
            count_next_s = CntW'(0);
        end else begin
            count_next_s = fifo_count_s + CntW'(push_s) - CntW'(pop_s);
        end
    end

    // Next-state logic of the run sequencer
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) state_d = ST_ISSUE;
                else            state_d = ST_IDLE;
            end
            ST_ISSUE: begin
                if (accept_s && (cmd_addr_q == EndAddr)) state_d = ST_DRAIN;
                else                                     state_d = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (fifo_empty_s && !cmdReadDataValid) state_d = ST_DONE;
                else                                   state_d = ST_DRAIN;
            end
            ST_DONE: begin
                if (start_ok_s) state_d = ST_ISSUE;
                else            state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command address, latched pattern select and compare results
    always_comb begin
        cmd_addr_d       = cmd_addr_q;
        pattern_sel_d    = pattern_sel_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        first_err_data_d = first_err_data_q;
        proto_err_d      = proto_err_q;
        if (start_ok_s) begin
            cmd_addr_d       = StartAddr;
            pattern_sel_d    = patternSel;
            err_count_d      = 16'h0000;
            first_err_addr_d = '0;
            first_err_data_d = '0;
            proto_err_d      = 1'b0;
        end else begin
            if (accept_s) cmd_addr_d = cmd_addr_q + AddrWidth'(1);
            else          cmd_addr_d = cmd_addr_q;
            if (proto_hit_s) proto_err_d = 1'b1;
            else             proto_err_d = proto_err_q;
            // Capture only on the very first mismatch of the run
            if (mismatch_s && (err_count_q == 16'h0000)) begin
                first_err_addr_d = fifo_head_s;
                first_err_data_d = cmdReadData;
            end else begin
                first_err_addr_d = first_err_addr_q;
                first_err_data_d = first_err_data_q;
            end
            if (mismatch_s && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'h0001;
            else                                         err_count_d = err_count_q;
        end
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        busy_d        = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
        done_d        = (state_d == ST_DONE);
        pass_d        = done_d && (err_count_d == 16'h0000) && !proto_err_d;
        cmd_trigger_d = (state_d == ST_ISSUE) && (count_next_s != CntW'(MaxOutstanding));
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            cmd_trigger_q    <= 1'b0;
            cmd_addr_q       <= StartAddr;
            pattern_sel_q    <= 1'b0;
            err_count_q      <= 16'h0000;
            first_err_addr_q <= '0;
            first_err_data_q <= '0;
            proto_err_q      <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cmd_trigger_q    <= cmd_trigger_d;
            cmd_addr_q       <= cmd_addr_d;
            pattern_sel_q    <= pattern_sel_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_data_q <= first_err_data_d;
            proto_err_q      <= proto_err_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign errCount     = err_count_q;
    assign firstErrAddr = first_err_addr_q;
    assign firstErrData = first_err_data_q;
    assign protoErr     = proto_err_q;
    assign cmdTrigger   = cmd_trigger_q;
    assign cmdAddr      = cmd_addr_q;
    assign cmdWrite     = 1'b0;

endmodule

// File: tb/tb_sdram_readback_checker.sv
// Directed bench: a small-range checker against a latency-configurable memory model,
// plus a second instance over 65540 words to exercise error-count saturation.
module tb_sdram_readback_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, pattern_sel, cmd_ready;
    logic        busy, done, pass_o, proto_err, cmd_trigger, cmd_write;
    logic [15:0] err_count, first_err_data, rd_data;
    logic [24:0] first_err_addr, cmd_addr;
    logic        rd_valid;

    logic        s_start, s_busy, s_done, s_pass, s_proto_err, s_cmd_trigger, s_cmd_write;
    logic [15:0] s_err_count, s_first_err_data;
    logic [24:0] s_first_err_addr, s_cmd_addr;
    logic        s_rd_valid = 1'b0;
    logic [15:0] s_rd_data  = 16'h0000;
    logic        s_cmd_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    sdram_readback_checker #(
        .StartAddr(25'h0000000), .EndAddr(25'h000000F), .PatternConst(16'hCAFE), .MaxOutstanding(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .patternSel(pattern_sel),
        .busy(busy), .done(done), .pass(pass_o), .errCount(err_count),
        .firstErrAddr(first_err_addr), .firstErrData(first_err_data), .protoErr(proto_err),
        .cmdReady(cmd_ready), .cmdTrigger(cmd_trigger), .cmdAddr(cmd_addr), .cmdWrite(cmd_write),
        .cmdReadData(rd_data), .cmdReadDataValid(rd_valid)
    );

    sdram_readback_checker #(
        .StartAddr(25'h0000000), .EndAddr(25'h0010003), .PatternConst(16'hCAFE), .MaxOutstanding(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .patternSel(1'b0),
        .busy(s_busy), .done(s_done), .pass(s_pass), .errCount(s_err_count),
        .firstErrAddr(s_first_err_addr), .firstErrData(s_first_err_data), .protoErr(s_proto_err),
        .cmdReady(s_cmd_ready), .cmdTrigger(s_cmd_trigger), .cmdAddr(s_cmd_addr), .cmdWrite(s_cmd_write),
        .cmdReadData(s_rd_data), .cmdReadDataValid(s_rd_valid)
    );

    // Memory model: fixed-latency pipeline, optional extra beat after the last word
    int          lat = 2;
    int          mode = 0;
    logic        arm_inject = 1'b0;
    logic        clr_mon = 1'b1;
    logic        pv [8];
    logic [24:0] pa [8];
    logic        inj_q, real_v, acc_s;
    logic [24:0] real_a;
    int          out_cnt, out_nxt, max_out, acc_cnt;

    function automatic logic [15:0] mem_word(input int m, input logic [24:0] a);
        logic [15:0] w;
        if (m == 0)                w = 16'hCAFE;
        else if (a == 25'h0000005) w = 16'h0000;
        else                       w = a[15:0];
        return w;
    endfunction

    assign acc_s = cmd_trigger && cmd_ready;

    always_comb begin
        real_v  = pv[lat-1];
        real_a  = pa[lat-1];
        out_nxt = out_cnt + (acc_s ? 1 : 0) - (real_v ? 1 : 0);
    end

    assign rd_valid = real_v | inj_q;
    assign rd_data  = inj_q ? 16'hCAFE : mem_word(mode, real_a);

    always @(posedge clk) begin
        if (clr_mon) begin
            for (int i = 0; i < 8; i++) begin
                pv[i] <= 1'b0;
                pa[i] <= 25'h0;
            end
            inj_q   <= 1'b0;
            out_cnt <= 0;
            max_out <= 0;
            acc_cnt <= 0;
        end else begin
            pv[0] <= acc_s;
            pa[0] <= cmd_addr;
            for (int i = 1; i < 8; i++) begin
                pv[i] <= pv[i-1];
                pa[i] <= pa[i-1];
            end
            inj_q   <= arm_inject && real_v && (real_a == 25'h000000F);
            out_cnt <= out_nxt;
            if (out_nxt > max_out) max_out <= out_nxt;
            acc_cnt <= acc_cnt + (acc_s ? 1 : 0);
        end
    end

    // Saturation instance: every read returns 0 one cycle after issue
    always @(posedge clk) s_rd_valid <= s_cmd_trigger && s_cmd_ready;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_monitors();
        clr_mon = 1'b1;
        tick();
        clr_mon = 1'b0;
    endtask

    task automatic wait_done(input bit sat, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sat ? s_done : done) break;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_start = 1'b0; pattern_sel = 1'b0; cmd_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        clr_mon = 1'b0;

        check("rst_trigger", cmd_trigger, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass_o, 1'b0);
        check("rst_errcount", err_count, 16'h0000);
        check("rst_protoerr", proto_err, 1'b0);
        check("rst_cmdaddr", cmd_addr, 25'h0000000);
        check("rst_firstaddr", first_err_addr, 25'h0000000);
        check("rst_cmdwrite", cmd_write, 1'b0);

        // Constant pattern, all words good
        pulse_start();
        check("t1_start_trigger", cmd_trigger, 1'b1);
        check("t1_start_busy", busy, 1'b1);
        wait_done(1'b0, 200);
        check("t1_done", done, 1'b1);
        check("t1_busy_low", busy, 1'b0);
        check("t1_pass", pass_o, 1'b1);
        check("t1_errcount", err_count, 16'h0000);
        check("t1_reads", acc_cnt, 16);
        check("t1_cmdaddr_end", cmd_addr, 25'h0000010);
        repeat (3) tick();
        check("t1_done_held", done, 1'b1);

        // Address pattern with one corrupted word; select changes after start must not matter
        mode = 1;
        clear_monitors();
        pattern_sel = 1'b1;
        pulse_start();
        pattern_sel = 1'b0;
        wait_done(1'b0, 200);
        check("t2_done", done, 1'b1);
        check("t2_errcount", err_count, 16'h0001);
        check("t2_firstaddr", first_err_addr, 25'h0000005);
        check("t2_firstdata", first_err_data, 16'h0000);
        check("t2_pass", pass_o, 1'b0);

        // Stall for 10 cycles with 6-cycle read latency
        mode = 0;
        lat  = 6;
        clear_monitors();
        pulse_start();
        repeat (3) tick();
        cmd_ready = 1'b0;
        check("t3_stall_addr_a", cmd_addr, 25'h0000003);
        check("t3_stall_trig_a", cmd_trigger, 1'b1);
        repeat (10) tick();
        check("t3_stall_addr_b", cmd_addr, 25'h0000003);
        check("t3_stall_trig_b", cmd_trigger, 1'b1);
        cmd_ready = 1'b1;
        wait_done(1'b0, 300);
        check("t3_done", done, 1'b1);
        check("t3_pass", pass_o, 1'b1);
        check("t3_max_outstanding", max_out, 4);
        check("t3_reads", acc_cnt, 16);

        // Extra read-data beat while draining with an empty FIFO
        lat = 2;
        arm_inject = 1'b1;
        clear_monitors();
        pulse_start();
        wait_done(1'b0, 200);
        arm_inject = 1'b0;
        check("t4_done", done, 1'b1);
        check("t4_protoerr", proto_err, 1'b1);
        check("t4_pass", pass_o, 1'b0);
        check("t4_errcount", err_count, 16'h0000);

        // Reset mid-issue; stale data afterwards must be ignored
        lat = 6;
        clear_monitors();
        pulse_start();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("t5_rst_trigger", cmd_trigger, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (12) tick();
        check("t5_late_protoerr", proto_err, 1'b0);
        check("t5_late_errcount", err_count, 16'h0000);
        check("t5_late_done", done, 1'b0);
        clear_monitors();
        pulse_start();
        wait_done(1'b0, 300);
        check("t5_done", done, 1'b1);
        check("t5_pass", pass_o, 1'b1);
        check("t5_reads", acc_cnt, 16);

        // 65540 mismatching words: count must stick at 16'hFFFF
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        wait_done(1'b1, 70000);
        check("t6_done", s_done, 1'b1);
        check("t6_errcount_sat", s_err_count, 16'hFFFF);
        check("t6_firstaddr", s_first_err_addr, 25'h0000000);
        check("t6_firstdata", s_first_err_data, 16'h0000);
        check("t6_pass", s_pass, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
